// File: rtl/demux1x4_8bit_buf_if.sv
// Bus bundle for the 1-to-4 buffered demux: one producer port and four
// consumer channels, each with a one-entry buffer exposed as data + full flag.
interface demux1x4_8bit_buf_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             in_valid;
    logic             in_ready;
    logic             sel0;
    logic             sel1;
    logic             bcast;
    logic [WIDTH-1:0] f0, f1, f2, f3;
    logic             v0, v1, v2, v3;
    logic             r0, r1, r2, r3;
    logic [7:0]       xfer_cnt;

    // master: producer and consumers (the environment around the demux)
    modport master (
        output din, in_valid, sel0, sel1, bcast, r0, r1, r2, r3,
        input  in_ready, f0, f1, f2, f3, v0, v1, v2, v3, xfer_cnt
    );

    // slave: the demux itself
    modport slave (
        input  din, in_valid, sel0, sel1, bcast, r0, r1, r2, r3,
        output in_ready, f0, f1, f2, f3, v0, v1, v2, v3, xfer_cnt
    );
endinterface

// File: rtl/demux1x4_8bit_buf.sv
// 1-to-4 demux with a one-entry buffer per channel, unicast or broadcast
// writes, and a wrapping 8-bit count of accepted input transfers.
module demux1x4_8bit_buf #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux1x4_8bit_buf_if.slave   bus
);
    logic [3:0]       r_vec;
    logic [1:0]       sel;
    logic [3:0]       v_all;
    logic [WIDTH-1:0] f_all [4];
    logic [3:0]       writable;
    logic [3:0]       target;
    logic [3:0]       wr;
    logic             in_ready_w;
    logic             accept;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;

    assign r_vec = {bus.r3, bus.r2, bus.r1, bus.r0};
    assign sel   = {bus.sel1, bus.sel0};

    // A broadcast only proceeds when every channel can take the word at once,
    // so a partially blocked broadcast never writes anything.
    assign in_ready_w = !rst && (bus.bcast ? (&writable) : writable[sel]);
    assign accept     = bus.in_valid && in_ready_w;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            logic             v_q;
            logic             v_d;
            logic [WIDTH-1:0] f_q;
            logic [WIDTH-1:0] f_d;

            assign writable[gi] = !v_q || r_vec[gi];
            assign target[gi]   = bus.bcast || (sel == 2'(gi));
            assign wr[gi]       = accept && target[gi];

            always_comb begin
                v_d = v_q;
                f_d = f_q;
                if (wr[gi]) begin
                    v_d = 1'b1;
                    f_d = bus.din;
                end else if (v_q && r_vec[gi]) begin
                    v_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    f_q <= '0;
                end else begin
                    v_q <= v_d;
                    f_q <= f_d;
                end
            end

            assign v_all[gi] = v_q;
            assign f_all[gi] = f_q;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q + 8'(accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready = in_ready_w;
    assign bus.xfer_cnt = cnt_q;
    assign bus.v0       = v_all[0];
    assign bus.v1       = v_all[1];
    assign bus.v2       = v_all[2];
    assign bus.v3       = v_all[3];
    assign bus.f0       = f_all[0];
    assign bus.f1       = f_all[1];
    assign bus.f2       = f_all[2];
    assign bus.f3       = f_all[3];
endmodule
